// File: rtl/sram_uart_tx_pkg.sv
// ---------------------------------------------------------------------------
// sram_uart_tx_pkg
// Shared types and constants for the SRAM-to-UART dump path:
//   - sram_uart_tx_state_type : top-level dump FSM states
//   - uart_tx_byte_state_type : 8N1 byte serialiser states
//   - DEFAULT_CLOCKS_PER_BIT  : 115200 baud at 50 MHz
//   - word_byte()             : selects the high or low byte of a 16-bit word
// Optional build macro: SRAM_UART_TX_CHECKSUM_EN adds the two checksum
// transmit states to the top-level state type.
// ---------------------------------------------------------------------------
package sram_uart_tx_pkg;

    localparam int DEFAULT_CLOCKS_PER_BIT = 434;
    localparam int DEFAULT_SRAM_ADDR_W    = 18;

    typedef enum logic [3:0] {
        S_DUMP_IDLE    = 4'd0,
        S_DUMP_READ_0  = 4'd1,
        S_DUMP_READ_1  = 4'd2,
        S_DUMP_READ_2  = 4'd3,
        S_DUMP_SEND_HI = 4'd4,
        S_DUMP_SEND_LO = 4'd5,
`ifdef SRAM_UART_TX_CHECKSUM_EN
        S_DUMP_SEND_CK_HI = 4'd7,
        S_DUMP_SEND_CK_LO = 4'd8,
`endif
        S_DUMP_FINISH  = 4'd6
    } sram_uart_tx_state_type;

    typedef enum logic [1:0] {
        S_TXB_IDLE  = 2'd0,
        S_TXB_START = 2'd1,
        S_TXB_DATA  = 2'd2,
        S_TXB_STOP  = 2'd3
    } uart_tx_byte_state_type;

    // High byte when hi is set, low byte otherwise.
    function automatic logic [7:0] word_byte(input logic [15:0] w, input logic hi);
        logic [7:0] b;
        if (hi) begin
            b = w[15:8];
        end else begin
            b = w[7:0];
        end
        return b;
    endfunction

endpackage

// File: rtl/sram_uart_tx_dump_uart_tx_byte.sv
// ---------------------------------------------------------------------------
// uart_tx_byte
// 8N1 byte serialiser: start bit 0, eight data bits LSB first, stop bit 1,
// each bit held CLOCKS_PER_BIT cycles.
// Ports:
//   clk_i, rst_i  : clock, asynchronous active-high reset
//   load_i        : accept byte_i (honoured in idle, or in the last stop-bit
//                   cycle so consecutive frames abut with no idle gap)
//   byte_i [7:0]  : byte to send
//   tx_o          : serial line, idle high (registered)
//   byte_done_o   : one-cycle pulse during the final stop-bit cycle; a load
//                   presented in that same cycle chains straight into the
//                   next start bit
// Requires CLOCKS_PER_BIT >= 3.
// ---------------------------------------------------------------------------
module uart_tx_byte
    import sram_uart_tx_pkg::*;
#(
    parameter int CLOCKS_PER_BIT = DEFAULT_CLOCKS_PER_BIT
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       load_i,
    input  logic [7:0] byte_i,
    output logic       tx_o,
    output logic       byte_done_o
);

    localparam int BAUD_W = $clog2(CLOCKS_PER_BIT);
    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLOCKS_PER_BIT - 1);
    localparam logic [BAUD_W-1:0] BAUD_PRE  = BAUD_W'(CLOCKS_PER_BIT - 2);
    localparam logic [BAUD_W-1:0] BAUD_ZERO = {BAUD_W{1'b0}};
    localparam logic [BAUD_W-1:0] BAUD_ONE  = {{(BAUD_W-1){1'b0}}, 1'b1};

    uart_tx_byte_state_type state_q, state_d;
    logic [BAUD_W-1:0] baud_q, baud_d;
    logic [2:0]        bit_idx_q, bit_idx_d;
    logic [7:0]        shreg_q, shreg_d;
    logic              tx_q, tx_d;
    logic              byte_done_q, byte_done_d;

    // Serialiser state register.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q     <= S_TXB_IDLE;
            baud_q      <= BAUD_ZERO;
            bit_idx_q   <= 3'd0;
            shreg_q     <= 8'h00;
            tx_q        <= 1'b1;
            byte_done_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            baud_q      <= baud_d;
            bit_idx_q   <= bit_idx_d;
            shreg_q     <= shreg_d;
            tx_q        <= tx_d;
            byte_done_q <= byte_done_d;
        end
    end

    // Next-state logic: tx_d is the line level for the next cycle, so the
    // line is registered and changes exactly on bit boundaries.
    always_comb begin
        state_d     = state_q;
        baud_d      = baud_q;
        bit_idx_d   = bit_idx_q;
        shreg_d     = shreg_q;
        tx_d        = tx_q;
        byte_done_d = 1'b0;
        case (state_q)
            S_TXB_IDLE: begin
                baud_d = BAUD_ZERO;
                if (load_i) begin
                    state_d = S_TXB_START;
                    shreg_d = byte_i;
                    tx_d    = 1'b0;
                end else begin
                    tx_d    = 1'b1;
                end
            end
            S_TXB_START: begin
                if (baud_q == BAUD_LAST) begin
                    baud_d    = BAUD_ZERO;
                    bit_idx_d = 3'd0;
                    state_d   = S_TXB_DATA;
                    tx_d      = shreg_q[0];
                end else begin
                    baud_d    = baud_q + BAUD_ONE;
                end
            end
            S_TXB_DATA: begin
                if (baud_q == BAUD_LAST) begin
                    baud_d = BAUD_ZERO;
                    if (bit_idx_q == 3'd7) begin
                        state_d = S_TXB_STOP;
                        tx_d    = 1'b1;
                    end else begin
                        bit_idx_d = bit_idx_q + 3'd1;
                        shreg_d   = {1'b0, shreg_q[7:1]};
                        tx_d      = shreg_q[1];
                    end
                end else begin
                    baud_d = baud_q + BAUD_ONE;
                end
            end
            S_TXB_STOP: begin
                if (baud_q == BAUD_LAST) begin
                    baud_d = BAUD_ZERO;
                    if (load_i) begin
                        state_d = S_TXB_START;
                        shreg_d = byte_i;
                        tx_d    = 1'b0;
                    end else begin
                        state_d = S_TXB_IDLE;
                        tx_d    = 1'b1;
                    end
                end else begin
                    baud_d = baud_q + BAUD_ONE;
                    // Registered pulse that lands on the final stop-bit cycle.
                    if (baud_q == BAUD_PRE) begin
                        byte_done_d = 1'b1;
                    end else begin
                        byte_done_d = 1'b0;
                    end
                end
            end
            default: begin
                state_d = S_TXB_IDLE;
                tx_d    = 1'b1;
            end
        endcase
    end

    assign tx_o        = tx_q;
    assign byte_done_o = byte_done_q;

endmodule

// File: rtl/sram_uart_tx_dump.sv
// ---------------------------------------------------------------------------
// sram_uart_tx_dump
// Reads Word_count 16-bit words from SRAM starting at Start_address and sends
// each as two 8N1 bytes (high byte first) with no gaps between bytes.
// Ports:
//   Clock_50, Reset         : clock, asynchronous active-high reset
//   Start                   : one-cycle request, sampled only when idle
//   Start_address, Word_count : captured on Start
//   SRAM_address_O          : read address (held stable between reads)
//   SRAM_we_n_O             : always 1, block only reads
//   SRAM_read_data_I        : read data, valid 2 cycles after the address
//   UART_TX_O               : serial line, idle high
//   Busy, Done              : transfer in progress / one-cycle completion
// Optional build macro: SRAM_UART_TX_CHECKSUM_EN appends a 16-bit sum of all
// sent words as two extra bytes before Done.
// ---------------------------------------------------------------------------
module sram_uart_tx_dump
    import sram_uart_tx_pkg::*;
#(
    parameter int CLOCKS_PER_BIT = DEFAULT_CLOCKS_PER_BIT,
    parameter int SRAM_ADDR_W    = DEFAULT_SRAM_ADDR_W
) (
    input  logic                   Clock_50,
    input  logic                   Reset,
    input  logic                   Start,
    input  logic [SRAM_ADDR_W-1:0] Start_address,
    input  logic [SRAM_ADDR_W-1:0] Word_count,
    output logic [SRAM_ADDR_W-1:0] SRAM_address_O,
    output logic                   SRAM_we_n_O,
    input  logic [15:0]            SRAM_read_data_I,
    output logic                   UART_TX_O,
    output logic                   Busy,
    output logic                   Done
);

    localparam logic [SRAM_ADDR_W-1:0] ADDR_ZERO = {SRAM_ADDR_W{1'b0}};
    localparam logic [SRAM_ADDR_W-1:0] ADDR_ONE  = {{(SRAM_ADDR_W-1){1'b0}}, 1'b1};

    sram_uart_tx_state_type state_q, state_d;
    logic [SRAM_ADDR_W-1:0] addr_q, addr_d;
    logic [SRAM_ADDR_W-1:0] cnt_q, cnt_d;       // words not yet captured
    logic [15:0]            word_q, word_d;     // word being transmitted
    logic [15:0]            hold_q, hold_d;     // prefetched next word
    logic                   hold_valid_q, hold_valid_d;
    logic [1:0]             pf_q, pf_d;         // prefetch read pipeline stage
    logic                   busy_q, busy_d;
    logic                   done_q, done_d;
    logic                   ser_load_s;
    logic [7:0]             ser_byte_s;
    logic                   ser_done_s;
`ifdef SRAM_UART_TX_CHECKSUM_EN
    logic [15:0]            sum_q, sum_d;
`endif

    uart_tx_byte #(
        .CLOCKS_PER_BIT (CLOCKS_PER_BIT)
    ) u_tx (
        .clk_i       (Clock_50),
        .rst_i       (Reset),
        .load_i      (ser_load_s),
        .byte_i      (ser_byte_s),
        .tx_o        (UART_TX_O),
        .byte_done_o (ser_done_s)
    );

    // Dump FSM and datapath registers.
    always_ff @(posedge Clock_50 or posedge Reset) begin
        if (Reset) begin
            state_q      <= S_DUMP_IDLE;
            addr_q       <= ADDR_ZERO;
            cnt_q        <= ADDR_ZERO;
            word_q       <= 16'h0000;
            hold_q       <= 16'h0000;
            hold_valid_q <= 1'b0;
            pf_q         <= 2'd0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
`ifdef SRAM_UART_TX_CHECKSUM_EN
            sum_q        <= 16'h0000;
`endif
        end else begin
            state_q      <= state_d;
            addr_q       <= addr_d;
            cnt_q        <= cnt_d;
            word_q       <= word_d;
            hold_q       <= hold_d;
            hold_valid_q <= hold_valid_d;
            pf_q         <= pf_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
`ifdef SRAM_UART_TX_CHECKSUM_EN
            sum_q        <= sum_d;
`endif
        end
    end

    // Next-state, SRAM sequencing, prefetch and serialiser loads.
    always_comb begin
        state_d      = state_q;
        addr_d       = addr_q;
        cnt_d        = cnt_q;
        word_d       = word_q;
        hold_d       = hold_q;
        hold_valid_d = hold_valid_q;
        pf_d         = pf_q;
        ser_load_s   = 1'b0;
        ser_byte_s   = 8'h00;
`ifdef SRAM_UART_TX_CHECKSUM_EN
        sum_d        = sum_q;
`endif
        case (state_q)
            S_DUMP_IDLE: begin
                if (Start) begin
                    hold_valid_d = 1'b0;
                    pf_d         = 2'd0;
`ifdef SRAM_UART_TX_CHECKSUM_EN
                    sum_d        = 16'h0000;
`endif
                    // A zero-length request leaves the address untouched.
                    if (Word_count == ADDR_ZERO) begin
                        state_d = S_DUMP_FINISH;
                    end else begin
                        addr_d  = Start_address;
                        cnt_d   = Word_count;
                        state_d = S_DUMP_READ_0;
                    end
                end else begin
                    state_d = S_DUMP_IDLE;
                end
            end
            S_DUMP_READ_0: state_d = S_DUMP_READ_1;
            S_DUMP_READ_1: state_d = S_DUMP_READ_2;
            S_DUMP_READ_2: begin
                // Data for the first address is valid now; send its high
                // byte straight from the bus so the start bit is next cycle.
                word_d     = SRAM_read_data_I;
                cnt_d      = cnt_q - ADDR_ONE;
`ifdef SRAM_UART_TX_CHECKSUM_EN
                sum_d      = sum_q + SRAM_read_data_I;
`endif
                ser_load_s = 1'b1;
                ser_byte_s = word_byte(SRAM_read_data_I, 1'b1);
                state_d    = S_DUMP_SEND_HI;
            end
            S_DUMP_SEND_HI: begin
                if (ser_done_s) begin
                    ser_load_s = 1'b1;
                    ser_byte_s = word_byte(word_q, 1'b0);
                    state_d    = S_DUMP_SEND_LO;
                    // Issue the next read while the low byte is on the line.
                    if (cnt_q != ADDR_ZERO) begin
                        addr_d = addr_q + ADDR_ONE;
                        pf_d   = 2'd1;
                    end else begin
                        pf_d   = 2'd0;
                    end
                end else begin
                    state_d = S_DUMP_SEND_HI;
                end
            end
            S_DUMP_SEND_LO: begin
                case (pf_q)
                    2'd1: pf_d = 2'd2;
                    2'd2: pf_d = 2'd3;
                    2'd3: begin
                        hold_d       = SRAM_read_data_I;
                        hold_valid_d = 1'b1;
                        cnt_d        = cnt_q - ADDR_ONE;
`ifdef SRAM_UART_TX_CHECKSUM_EN
                        sum_d        = sum_q + SRAM_read_data_I;
`endif
                        pf_d         = 2'd0;
                    end
                    default: pf_d = 2'd0;
                endcase
                if (ser_done_s) begin
                    if (hold_valid_q) begin
                        word_d       = hold_q;
                        hold_valid_d = 1'b0;
                        ser_load_s   = 1'b1;
                        ser_byte_s   = word_byte(hold_q, 1'b1);
                        state_d      = S_DUMP_SEND_HI;
                    end else begin
`ifdef SRAM_UART_TX_CHECKSUM_EN
                        ser_load_s = 1'b1;
                        ser_byte_s = word_byte(sum_q, 1'b1);
                        state_d    = S_DUMP_SEND_CK_HI;
`else
                        state_d    = S_DUMP_FINISH;
`endif
                    end
                end else begin
                    state_d = S_DUMP_SEND_LO;
                end
            end
`ifdef SRAM_UART_TX_CHECKSUM_EN
            S_DUMP_SEND_CK_HI: begin
                if (ser_done_s) begin
                    ser_load_s = 1'b1;
                    ser_byte_s = word_byte(sum_q, 1'b0);
                    state_d    = S_DUMP_SEND_CK_LO;
                end else begin
                    state_d    = S_DUMP_SEND_CK_HI;
                end
            end
            S_DUMP_SEND_CK_LO: begin
                if (ser_done_s) begin
                    state_d = S_DUMP_FINISH;
                end else begin
                    state_d = S_DUMP_SEND_CK_LO;
                end
            end
`endif
            S_DUMP_FINISH: state_d = S_DUMP_IDLE;
            default:       state_d = S_DUMP_IDLE;
        endcase
        // Status flags are registered from the next state so Done lines up
        // with FINISH and Busy drops the cycle after.
        busy_d = (state_d != S_DUMP_IDLE);
        done_d = (state_d == S_DUMP_FINISH);
    end

    assign SRAM_address_O = addr_q;
    assign SRAM_we_n_O    = 1'b1;
    assign Busy           = busy_q;
    assign Done           = done_q;

endmodule

// File: tb/tb_sram_uart_tx_dump.sv
// ---------------------------------------------------------------------------
// tb_sram_uart_tx_dump
// Directed bench for sram_uart_tx_dump: 2-cycle-latency SRAM model, UART
// frame decoder, expected-byte and expected-address scoreboards.
// Honours SRAM_UART_TX_CHECKSUM_EN when computing expected bytes.
// ---------------------------------------------------------------------------
module tb_sram_uart_tx_dump;

    localparam int CPB = 434;
    localparam int H   = CPB / 2;
`ifdef SRAM_UART_TX_CHECKSUM_EN
    localparam int CK = 1;
`else
    localparam int CK = 0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [17:0] start_addr = 18'd0;
    logic [17:0] wcount = 18'd0;
    logic [17:0] sram_addr;
    logic        sram_we_n;
    logic [15:0] sram_rdata;
    logic        tx;
    logic        busy;
    logic        done;

    sram_uart_tx_dump #(
        .CLOCKS_PER_BIT (CPB),
        .SRAM_ADDR_W    (18)
    ) dut (
        .Clock_50         (clk),
        .Reset            (rst),
        .Start            (start),
        .Start_address    (start_addr),
        .Word_count       (wcount),
        .SRAM_address_O   (sram_addr),
        .SRAM_we_n_O      (sram_we_n),
        .SRAM_read_data_I (sram_rdata),
        .UART_TX_O        (tx),
        .Busy             (busy),
        .Done             (done)
    );

    always #10 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // SRAM model: data valid two cycles after the address is presented.
    logic [15:0] mem [logic [17:0]];
    logic [15:0] rd1, rd2;
    always @(posedge clk) begin
        rd1 <= mem.exists(sram_addr) ? mem[sram_addr] : 16'hDEAD;
        rd2 <= rd1;
    end
    assign sram_rdata = rd2;

    // UART decoder: samples mid-bit; pushes {stop, data, start}.
    logic       rx_act = 1'b0;
    int         rx_cnt = 0;
    logic [9:0] rx_sh = 10'h000;
    logic [9:0] rx_q[$];
    int         rx_start_q[$];
    always @(negedge clk) begin
        if (rst) begin
            rx_act <= 1'b0;
            rx_cnt <= 0;
        end else if (!rx_act) begin
            if (tx === 1'b0) begin
                rx_act <= 1'b1;
                rx_cnt <= 1;
                rx_start_q.push_back(cyc);
            end
        end else begin
            rx_cnt <= rx_cnt + 1;
            if (rx_cnt >= H && ((rx_cnt - H) % CPB) == 0) begin
                rx_sh[(rx_cnt - H) / CPB] <= tx;
                if ((rx_cnt - H) / CPB == 9) begin
                    rx_q.push_back({tx, rx_sh[8:0]});
                    rx_act <= 1'b0;
                end
            end
        end
    end

    // Done pulse counter and SRAM address-change log.
    int          done_cnt = 0;
    logic [17:0] last_a = 18'd0;
    logic [17:0] addr_seen[$];
    always @(negedge clk) begin
        if (done === 1'b1) done_cnt <= done_cnt + 1;
        last_a <= sram_addr;
        if (!rst && sram_addr !== last_a) addr_seen.push_back(sram_addr);
    end

    logic [9:0]  exp_q[$];
    logic [17:0] exp_addr_q[$];
    int          n_cmp = 0;
    int          n_err = 0;
    int          t0 = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Queue expectations from the SRAM model, then pulse Start (cycle 0).
    task automatic start_xfer(input logic [17:0] a, input logic [17:0] n);
        logic [15:0] w;
        logic [15:0] s;
        logic [17:0] ad;
        exp_q.delete(); exp_addr_q.delete();
        rx_q.delete(); rx_start_q.delete(); addr_seen.delete();
        s  = 16'h0000;
        ad = a;
        for (int i = 0; i < int'(n); i++) begin
            w = mem.exists(ad) ? mem[ad] : 16'hDEAD;
            s = s + w;
            exp_q.push_back({1'b1, w[15:8], 1'b0});
            exp_q.push_back({1'b1, w[7:0], 1'b0});
            exp_addr_q.push_back(ad);
            ad = ad + 18'd1;
        end
`ifdef SRAM_UART_TX_CHECKSUM_EN
        if (n != 18'd0) begin
            exp_q.push_back({1'b1, s[15:8], 1'b0});
            exp_q.push_back({1'b1, s[7:0], 1'b0});
        end
`endif
        @(negedge clk);
        start_addr = a;
        wcount     = n;
        start      = 1'b1;
        t0         = cyc;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Bounded wait for Done; rel is its cycle number relative to Start.
    task automatic wait_done(input int budget, output int rel);
        rel = -1;
        for (int i = 0; i < budget; i++) begin
            if (done === 1'b1) begin
                rel = cyc - t0;
                break;
            end
            @(negedge clk);
        end
    endtask

    task automatic compare_stream(input string tag);
        logic [9:0]  e;
        logic [9:0]  o;
        logic [17:0] ea;
        logic [17:0] oa;
        int          k;
        check({tag, "_nbytes"}, rx_q.size(), exp_q.size());
        k = 0;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            o = (rx_q.size() > 0) ? rx_q.pop_front() : 10'bxxxxxxxxxx;
            check($sformatf("%s_byte%0d", tag, k), {22'd0, o}, {22'd0, e});
            check($sformatf("%s_tstart%0d", tag, k),
                  (k < rx_start_q.size()) ? rx_start_q[k] - t0 : -1, 4 + 10 * CPB * k);
            k++;
        end
        k = 0;
        while (exp_addr_q.size() > 0) begin
            ea = exp_addr_q.pop_front();
            oa = (addr_seen.size() > 0) ? addr_seen.pop_front() : 18'h3FFFF;
            check($sformatf("%s_addr%0d", tag, k), {14'd0, oa}, {14'd0, ea});
            k++;
        end
    endtask

    initial begin
        int rel;
        int dsnap;

        // Reset state.
        repeat (3) @(negedge clk);
        check("rst_tx", tx, 1'b1);
        check("rst_we_n", sram_we_n, 1'b1);
        check("rst_addr", sram_addr, 18'd0);
        check("rst_busy", busy, 1'b0);
        check("rst_done", done, 1'b0);
        rst = 1'b0;
        repeat (3) @(negedge clk);

        // Single word: A5 then 5A, Done at 4 + 20*CPB.
        mem[18'd5] = 16'hA55A;
        start_xfer(18'd5, 18'd1);
        check("single_busy_c1", busy, 1'b1);
        wait_done(25 * CPB * (1 + CK), rel);
        check("single_done_cyc", rel, 4 + 20 * CPB * (1 + CK));
        start      = 1'b1;          // Start in the Done cycle must be ignored
        start_addr = 18'd9;
        @(negedge clk);
        start = 1'b0;
        check("single_busy_after", busy, 1'b0);
        check("single_done_width", done, 1'b0);
        @(negedge clk);
        check("single_start_in_done_ignored", busy, 1'b0);
        compare_stream("single");

        // Zero count: Done at cycle 1, nothing sent, address kept.
        start_xfer(18'd100, 18'd0);
        wait_done(20, rel);
        check("zero_done_cyc", rel, 1);
        check("zero_busy_c1", busy, 1'b1);
        @(negedge clk);
        check("zero_busy_c2", busy, 1'b0);
        repeat (20) @(negedge clk);
        check("zero_tx", tx, 1'b1);
        check("zero_nbytes", rx_q.size(), 0);
        check("zero_addr", sram_addr, 18'd5);

        // Address wrap: 262143 then 0.
        mem[18'd262143] = 16'h1234;
        mem[18'd0]      = 16'h5678;
        start_xfer(18'd262143, 18'd2);
        wait_done(25 * CPB * (2 + CK), rel);
        check("wrap_done_cyc", rel, 4 + 20 * CPB * (2 + CK));
        @(negedge clk);
        compare_stream("wrap");

        // Reset during data bit 3 of the second byte (bit is 0 for A5).
        mem[18'd40] = 16'h3CA5;
        start_xfer(18'd40, 18'd1);
        while (cyc - t0 < 4 + 14 * CPB + 200) @(negedge clk);
        check("abort_tx_low_before", tx, 1'b0);
        dsnap = done_cnt;
        rst = 1'b1;
        #1;
        check("abort_tx", tx, 1'b1);
        check("abort_busy", busy, 1'b0);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (3 * CPB) @(negedge clk);
        check("abort_no_done", done_cnt, dsnap);
        check("abort_nbytes", rx_q.size(), 1);
        check("abort_byte0", (rx_q.size() > 0) ? rx_q[0] : 10'bxxxxxxxxxx, {1'b1, 8'h3C, 1'b0});

        // Start while busy is ignored; also the first Start after the abort.
        mem[18'd64] = 16'hFFFF;
        mem[18'd65] = 16'h0002;
        mem[18'd7]  = 16'hBEEF;
        start_xfer(18'd64, 18'd2);
        while (cyc - t0 < 3000) @(negedge clk);
        start_addr = 18'd7;
        wcount     = 18'd1;
        start      = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done(25 * CPB * (2 + CK), rel);
        check("busy_done_cyc", rel, 4 + 20 * CPB * (2 + CK));
        @(negedge clk);
        check("busy_busy_after", busy, 1'b0);
        compare_stream("busy");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
